// File: rtl/deserializer_if.sv
// Handshake bundle for the deserializer: serial input side and FIFO output side.
// Signal names keep their _i/_o suffixes from the deserializer's point of view.
interface deserializer_if #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
);
    logic                     ser_data_i;
    logic                     ser_val_i;
    logic [DATA_W-1:0]        data_o;
    logic                     data_val_o;
    logic                     data_rdy_i;
    logic                     rx_busy_o;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     frame_err_o;
    logic                     ovf_o;

    modport master (
        output ser_data_i, ser_val_i, data_rdy_i,
        input  data_o, data_val_o, rx_busy_o, level_o, frame_err_o, ovf_o
    );

    modport slave (
        input  ser_data_i, ser_val_i, data_rdy_i,
        output data_o, data_val_o, rx_busy_o, level_o, frame_err_o, ovf_o
    );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver feeding a small FIFO with a registered head.
// Truncated frames raise frame_err_o; words arriving on a full FIFO raise ovf_o.
module deserializer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    deserializer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    logic [DATA_W-2:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              frame_err;
    logic [DATA_W-1:0] word;
    logic              push;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] head_next;
    logic              ovf;
    logic              pop;
    logic              full;
    logic              wr_en;

    // The incoming bit completes the word on the same edge it is sampled.
    assign word = {shreg, bus.ser_data_i};
    assign push = bus.ser_val_i && (cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shreg     <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (bus.ser_val_i) begin
                shreg <= word[DATA_W-2:0];
                cnt   <= (cnt == LAST_BIT) ? '0 : cnt + CNT_W'(1);
            end else if (cnt != '0) begin
                shreg     <= '0;
                cnt       <= '0;
                frame_err <= 1'b1;
            end
        end
    end

    assign pop        = (level != '0) && bus.data_rdy_i;
    assign full       = (level == FULL_LVL);
    assign wr_en      = push && (!full || pop);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    // NOTE: storage has no reset; validity is tracked by level, and data_q masks stale entries.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= word;
    end

    // Next head: the following stored entry on a pop, or the arriving word when it
    // lands in an empty (or emptying) FIFO. Keeps data_o registered with 1-cycle push latency.
    // NOTE: head_next gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_next = data_q;
        if (pop) begin
            if (level == ONE_LVL) begin
                if (wr_en) head_next = word;
            end else begin
                head_next = mem[rd_ptr_inc];
            end
        end else if ((level == '0) && wr_en) begin
            head_next = word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            data_q <= '0;
            ovf    <= 1'b0;
        end else begin
            data_q <= head_next;
            ovf    <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr_inc;
            level <= level + LVL_W'(wr_en) - LVL_W'(pop);
        end
    end

    assign bus.data_o      = data_q;
    assign bus.data_val_o  = (level != '0);
    assign bus.rx_busy_o   = (cnt != '0);
    assign bus.level_o     = level;
    assign bus.frame_err_o = frame_err;
    assign bus.ovf_o       = ovf;
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (DATA_W=6, DEPTH=4): one task per scenario,
// inputs driven and outputs sampled 1 ns after each rising edge.
module tb_deserializer;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    deserializer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    deserializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.ser_val_i  = 1'b1;
        bus.ser_data_i = b;
        tick();
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic go_idle();
        bus.ser_val_i  = 1'b0;
        bus.ser_data_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.data_o !== 6'h00) begin
            $display("FAIL rst_data_o: got %h expected 00", bus.data_o); failures++;
        end
        checks++;
        if ({bus.data_val_o, bus.rx_busy_o, bus.frame_err_o, bus.ovf_o} !== 4'b0000) begin
            $display("FAIL rst_flags: got %b expected 0000",
                     {bus.data_val_o, bus.rx_busy_o, bus.frame_err_o, bus.ovf_o}); failures++;
        end
        checks++;
        if (bus.level_o !== 3'd0) begin
            $display("FAIL rst_level: got %0d expected 0", bus.level_o); failures++;
        end
    endtask

    task automatic test_single();
        bus.data_rdy_i = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        checks++;
        if (bus.rx_busy_o !== 1'b1 || bus.data_val_o !== 1'b0) begin
            $display("FAIL single_partial: got busy=%b val=%b expected busy=1 val=0",
                     bus.rx_busy_o, bus.data_val_o); failures++;
        end
        send_bit(1'b1);
        go_idle();
        checks++;
        if (bus.data_val_o !== 1'b1 || bus.data_o !== 6'h2D) begin
            $display("FAIL single_word: got val=%b data=%h expected val=1 data=2d",
                     bus.data_val_o, bus.data_o); failures++;
        end
        checks++;
        if (bus.rx_busy_o !== 1'b0 || bus.level_o !== 3'd1) begin
            $display("FAIL single_state: got busy=%b level=%0d expected busy=0 level=1",
                     bus.rx_busy_o, bus.level_o); failures++;
        end
        tick();
        checks++;
        if (bus.data_val_o !== 1'b0 || bus.level_o !== 3'd0 || bus.frame_err_o !== 1'b0) begin
            $display("FAIL single_popped: got val=%b level=%0d err=%b expected 0 0 0",
                     bus.data_val_o, bus.level_o, bus.frame_err_o); failures++;
        end
        bus.data_rdy_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.data_rdy_i = 1'b0;
        send_word(6'h3F);
        send_word(6'h01);
        go_idle();
        checks++;
        if (bus.level_o !== 3'd2 || bus.data_o !== 6'h3F || bus.rx_busy_o !== 1'b0) begin
            $display("FAIL b2b_level: got level=%0d data=%h busy=%b expected 2 3f 0",
                     bus.level_o, bus.data_o, bus.rx_busy_o); failures++;
        end
        bus.data_rdy_i = 1'b1;
        tick();
        checks++;
        if (bus.data_o !== 6'h01 || bus.level_o !== 3'd1) begin
            $display("FAIL b2b_second: got data=%h level=%0d expected 01 1",
                     bus.data_o, bus.level_o); failures++;
        end
        tick();
        bus.data_rdy_i = 1'b0;
        checks++;
        if (bus.data_val_o !== 1'b0 || bus.level_o !== 3'd0) begin
            $display("FAIL b2b_empty: got val=%b level=%0d expected 0 0",
                     bus.data_val_o, bus.level_o); failures++;
        end
    endtask

    task automatic test_frame_err();
        bus.data_rdy_i = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        checks++;
        if (bus.rx_busy_o !== 1'b1 || bus.frame_err_o !== 1'b0) begin
            $display("FAIL ferr_busy: got busy=%b err=%b expected 1 0",
                     bus.rx_busy_o, bus.frame_err_o); failures++;
        end
        go_idle();
        tick();
        checks++;
        if (bus.frame_err_o !== 1'b1 || bus.rx_busy_o !== 1'b0 || bus.level_o !== 3'd0) begin
            $display("FAIL ferr_pulse: got err=%b busy=%b level=%0d expected 1 0 0",
                     bus.frame_err_o, bus.rx_busy_o, bus.level_o); failures++;
        end
        tick();
        checks++;
        if (bus.frame_err_o !== 1'b0) begin
            $display("FAIL ferr_one_cycle: got err=%b expected 0", bus.frame_err_o); failures++;
        end
        send_word(6'h15);
        go_idle();
        checks++;
        if (bus.data_o !== 6'h15 || bus.level_o !== 3'd1 || bus.frame_err_o !== 1'b0) begin
            $display("FAIL ferr_recover: got data=%h level=%0d err=%b expected 15 1 0",
                     bus.data_o, bus.level_o, bus.frame_err_o); failures++;
        end
        bus.data_rdy_i = 1'b1;
        tick();
        bus.data_rdy_i = 1'b0;
    endtask

    task automatic drain(input logic [DATA_W-1:0] exp [4], input string tag);
        bus.data_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.data_val_o !== 1'b1 || bus.data_o !== exp[i]) begin
                $display("FAIL %s_word%0d: got val=%b data=%h expected val=1 data=%h",
                         tag, i, bus.data_val_o, bus.data_o, exp[i]); failures++;
            end
            tick();
        end
        bus.data_rdy_i = 1'b0;
        checks++;
        if (bus.data_val_o !== 1'b0 || bus.level_o !== 3'd0) begin
            $display("FAIL %s_empty: got val=%b level=%0d expected 0 0",
                     tag, bus.data_val_o, bus.level_o); failures++;
        end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] exp [4];
        exp = '{6'h01, 6'h02, 6'h03, 6'h04};
        bus.data_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) send_word(exp[i]);
        checks++;
        if (bus.level_o !== 3'd4 || bus.ovf_o !== 1'b0) begin
            $display("FAIL ovf_full: got level=%0d ovf=%b expected 4 0",
                     bus.level_o, bus.ovf_o); failures++;
        end
        send_word(6'h05);
        go_idle();
        checks++;
        if (bus.ovf_o !== 1'b1 || bus.level_o !== 3'd4) begin
            $display("FAIL ovf_pulse: got ovf=%b level=%0d expected 1 4",
                     bus.ovf_o, bus.level_o); failures++;
        end
        tick();
        checks++;
        if (bus.ovf_o !== 1'b0) begin
            $display("FAIL ovf_one_cycle: got ovf=%b expected 0", bus.ovf_o); failures++;
        end
        drain(exp, "ovf");
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] exp [4];
        bus.data_rdy_i = 1'b0;
        send_word(6'h0A); send_word(6'h0B); send_word(6'h0C); send_word(6'h0D);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        bus.data_rdy_i = 1'b1;
        send_bit(1'b0);
        bus.data_rdy_i = 1'b0;
        go_idle();
        checks++;
        if (bus.ovf_o !== 1'b0 || bus.level_o !== 3'd4 || bus.data_o !== 6'h0B) begin
            $display("FAIL fpp_same_edge: got ovf=%b level=%0d data=%h expected 0 4 0b",
                     bus.ovf_o, bus.level_o, bus.data_o); failures++;
        end
        exp = '{6'h0B, 6'h0C, 6'h0D, 6'h0E};
        drain(exp, "fpp");
    endtask

    task automatic test_reset_mid();
        bus.data_rdy_i = 1'b0;
        send_word(6'h11);
        send_word(6'h22);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (bus.level_o !== 3'd2 || bus.rx_busy_o !== 1'b1) begin
            $display("FAIL rmid_pre: got level=%0d busy=%b expected 2 1",
                     bus.level_o, bus.rx_busy_o); failures++;
        end
        go_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.data_val_o, bus.rx_busy_o, bus.frame_err_o, bus.ovf_o} !== 4'b0000 ||
            bus.level_o !== 3'd0 || bus.data_o !== 6'h00) begin
            $display("FAIL rmid_async: got val=%b busy=%b err=%b ovf=%b level=%0d data=%h expected all 0",
                     bus.data_val_o, bus.rx_busy_o, bus.frame_err_o, bus.ovf_o,
                     bus.level_o, bus.data_o); failures++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.frame_err_o !== 1'b0 || bus.ovf_o !== 1'b0 || bus.data_val_o !== 1'b0) begin
            $display("FAIL rmid_no_pulse: got err=%b ovf=%b val=%b expected 0 0 0",
                     bus.frame_err_o, bus.ovf_o, bus.data_val_o); failures++;
        end
        send_word(6'h2A);
        go_idle();
        checks++;
        if (bus.data_o !== 6'h2A || bus.level_o !== 3'd1 || bus.data_val_o !== 1'b1) begin
            $display("FAIL rmid_recover: got data=%h level=%0d val=%b expected 2a 1 1",
                     bus.data_o, bus.level_o, bus.data_val_o); failures++;
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.ser_data_i = 1'b0;
        bus.ser_val_i  = 1'b0;
        bus.data_rdy_i = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
